// File: rtl/wb_stage_if.sv
// Bundle of memory-stage inputs and write-back outputs of the MEM/WB stage.
// The master side is whatever drives the memory-stage results (the MEM stage
// or a testbench); the slave side is wb_stage itself.
interface wb_stage_if;
    // Memory-stage results presented to the WB register
    logic        M_Valid;
    logic        M_RegWrite;
    logic [4:0]  M_A3;
    logic [1:0]  M_WbSel;
    logic [2:0]  M_LoadType;
    logic [31:0] M_ALUOut;
    logic [31:0] M_MemRD;
    logic [31:0] M_PC4;

    // Register-file write port and trace outputs
    logic        W_Valid;
    logic        W_RegWrite;
    logic [4:0]  W_A3;
    logic [31:0] W_WriteData;
    logic [31:0] W_PC4;
    logic [31:0] RetireCount;

    modport master (
        output M_Valid, M_RegWrite, M_A3, M_WbSel, M_LoadType,
               M_ALUOut, M_MemRD, M_PC4,
        input  W_Valid, W_RegWrite, W_A3, W_WriteData, W_PC4, RetireCount
    );

    modport slave (
        input  M_Valid, M_RegWrite, M_A3, M_WbSel, M_LoadType,
               M_ALUOut, M_MemRD, M_PC4,
        output W_Valid, W_RegWrite, W_A3, W_WriteData, W_PC4, RetireCount
    );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back datapath.
// Captures memory-stage results, aligns and extends load data, selects the
// register-file write value and keeps a retired-instruction counter.
module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    wb_stage_if.slave   bus
);

    // Write-source select encodings
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PC8  = 2'b10;
    localparam logic [1:0] WB_ZERO = 2'b11;

    // Load-type encodings; unlisted codes behave as lw
    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LBU = 3'b001;
    localparam logic [2:0] LT_LB  = 3'b010;
    localparam logic [2:0] LT_LHU = 3'b011;
    localparam logic [2:0] LT_LH  = 3'b100;

    // Aligns the addressed byte/halfword of a memory word and extends it.
    // Halfword selection uses only offset bit 1; bit 0 is ignored.
    function automatic logic [31:0] f_load_extend(
        input logic [31:0] i_word,
        input logic [1:0]  i_off,
        input logic [2:0]  i_type
    );
        logic signed [7:0]  v_byte;
        logic signed [15:0] v_half;
        logic [31:0]        v_res;
        v_byte = i_word[8*i_off +: 8];
        v_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        case (i_type)
            LT_LW:   v_res = i_word;
            LT_LBU:  v_res = {24'h0, v_byte};
            LT_LB:   v_res = 32'(v_byte);
            LT_LHU:  v_res = {16'h0, v_half};
            LT_LH:   v_res = 32'(v_half);
            default: v_res = i_word;
        endcase
        return v_res;
    endfunction

    // WB pipeline register fields
    logic        r_Valid;
    logic        r_RegWrite;
    logic [4:0]  r_A3;
    logic [1:0]  r_WbSel;
    logic [2:0]  r_LoadType;
    logic [31:0] r_ALUOut;
    logic [31:0] r_MemRD;
    logic [31:0] r_PC4;
    logic [31:0] r_RetireCount;

    // Combinational write-back values
    logic [31:0] w_LoadData;
    logic [31:0] w_PC8;
    logic [31:0] w_WriteData;
    logic        w_RegWrite;
    logic        w_Advance;

    // A normal load happens only when no reset, flush or stall is pending
    assign w_Advance = !Flush && !Stall;

    // Pipeline register: reset clears everything, flush inserts a bubble
    // while preserving PC4, stall holds, otherwise capture the MEM stage.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_Valid    <= 1'b0;
            r_RegWrite <= 1'b0;
            r_A3       <= 5'd0;
            r_WbSel    <= WB_ALU;
            r_LoadType <= LT_LW;
            r_ALUOut   <= 32'h0;
            r_MemRD    <= 32'h0;
            r_PC4      <= RESET_PC;
        end else if (Flush) begin
            r_Valid    <= 1'b0;
            r_RegWrite <= 1'b0;
            r_A3       <= 5'd0;
            r_WbSel    <= WB_ALU;
            r_LoadType <= LT_LW;
            r_ALUOut   <= 32'h0;
            r_MemRD    <= 32'h0;
        end else if (!Stall) begin
            r_Valid    <= bus.M_Valid;
            r_RegWrite <= bus.M_RegWrite;
            r_A3       <= bus.M_A3;
            r_WbSel    <= bus.M_WbSel;
            r_LoadType <= bus.M_LoadType;
            r_ALUOut   <= bus.M_ALUOut;
            r_MemRD    <= bus.M_MemRD;
            r_PC4      <= bus.M_PC4;
        end
    end

    // Retired-instruction counter: counts real instructions entering WB,
    // wrapping naturally at 2^32.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_RetireCount <= 32'h0;
        end else if (w_Advance && bus.M_Valid) begin
            r_RetireCount <= r_RetireCount + 32'd1;
        end
    end

    assign w_LoadData = f_load_extend(r_MemRD, r_ALUOut[1:0], r_LoadType);
    assign w_PC8      = r_PC4 + 32'd4;

    // Bubbles and writes to $0 never reach the register file
    assign w_RegWrite = r_Valid && r_RegWrite && (r_A3 != 5'd0);

    // Select the register-file write value from the registered source
    always_comb begin
        w_WriteData = 32'h0;
        case (r_WbSel)
            WB_ALU:  w_WriteData = r_ALUOut;
            WB_MEM:  w_WriteData = w_LoadData;
            WB_PC8:  w_WriteData = w_PC8;
            WB_ZERO: w_WriteData = 32'h0;
            default: w_WriteData = 32'h0;
        endcase
    end

    assign bus.W_Valid     = r_Valid;
    assign bus.W_RegWrite  = w_RegWrite;
    assign bus.W_A3        = r_A3;
    assign bus.W_WriteData = w_WriteData;
    assign bus.W_PC4       = r_PC4;
    assign bus.RetireCount = r_RetireCount;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard testbench for wb_stage: directed vectors push hand-computed
// expected outputs tagged with the clock edge they are due after; a monitor
// compares them on the falling edge.
module tb_wb_stage;

    logic Clk;
    logic Reset;
    logic Stall;
    logic Flush;

    wb_stage_if bus ();

    wb_stage #(.RESET_PC(32'h0000_3000)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Stall (Stall),
        .Flush (Flush),
        .bus   (bus.slave)
    );

    typedef struct packed {
        int          due;
        logic        v;
        logic        rw;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [31:0] rc;
    } exp_t;

    exp_t exp_q[$];
    int   edgecnt = 0;
    int   checks  = 0;
    int   errors  = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count rising edges so expectations can be matched to the right edge
    always @(posedge Clk) edgecnt <= edgecnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, edgecnt);
        end
    endtask

    // Monitor: compare every expectation whose edge has passed
    always @(negedge Clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= edgecnt) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("W_Valid",     {31'h0, bus.W_Valid},    {31'h0, e.v});
            chk("W_RegWrite",  {31'h0, bus.W_RegWrite}, {31'h0, e.rw});
            chk("W_A3",        {27'h0, bus.W_A3},       {27'h0, e.a3});
            chk("W_WriteData", bus.W_WriteData,         e.wd);
            chk("W_PC4",       bus.W_PC4,               e.pc4);
            chk("RetireCount", bus.RetireCount,         e.rc);
        end
    end

    // Drive one cycle of stimulus and queue the outputs expected after the edge
    task automatic step(
        input logic rst, input logic stl, input logic fl,
        input logic v, input logic rw, input logic [4:0] a3,
        input logic [1:0] ws, input logic [2:0] lt,
        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
        input logic e_v, input logic e_rw, input logic [4:0] e_a3,
        input logic [31:0] e_wd, input logic [31:0] e_pc4, input logic [31:0] e_rc
    );
        exp_t e;
        Reset              = rst;
        Stall              = stl;
        Flush              = fl;
        bus.M_Valid        = v;
        bus.M_RegWrite     = rw;
        bus.M_A3           = a3;
        bus.M_WbSel        = ws;
        bus.M_LoadType     = lt;
        bus.M_ALUOut       = alu;
        bus.M_MemRD        = mem;
        bus.M_PC4          = pc4;
        e.due = edgecnt + 1;
        e.v   = e_v;
        e.rw  = e_rw;
        e.a3  = e_a3;
        e.wd  = e_wd;
        e.pc4 = e_pc4;
        e.rc  = e_rc;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    localparam logic [31:0] MRD = 32'h80FF_7F01;

    initial begin
        // rst stl fl | v rw a3 ws lt alu mem pc4 | exp v rw a3 wd pc4 rc
        step(1,0,0, 1,1,5'd9,2'b00,3'd0,32'hFFFF_FFFF,MRD,32'h0000_1111, 0,0,5'd0,32'h0,32'h0000_3000,32'd0);
        step(1,0,0, 0,0,5'd0,2'b00,3'd0,32'h0,32'h0,32'h0, 0,0,5'd0,32'h0,32'h0000_3000,32'd0);
        // Idle bubble
        step(0,0,0, 0,0,5'd0,2'b00,3'd0,32'h0,32'h0,32'h0000_3000, 0,0,5'd0,32'h0,32'h0000_3000,32'd0);
        // ALU write
        step(0,0,0, 1,1,5'd5,2'b00,3'd0,32'h1234_5678,32'h0,32'h0000_3004, 1,1,5'd5,32'h1234_5678,32'h0000_3004,32'd1);
        // Loads from 80FF_7F01
        step(0,0,0, 1,1,5'd6,2'b01,3'b010,32'h3,MRD,32'h0000_3008, 1,1,5'd6,32'hFFFF_FF80,32'h0000_3008,32'd2);
        step(0,0,0, 1,1,5'd7,2'b01,3'b001,32'h2,MRD,32'h0000_300C, 1,1,5'd7,32'h0000_00FF,32'h0000_300C,32'd3);
        step(0,0,0, 1,1,5'd8,2'b01,3'b100,32'h2,MRD,32'h0000_3010, 1,1,5'd8,32'hFFFF_80FF,32'h0000_3010,32'd4);
        step(0,0,0, 1,1,5'd9,2'b01,3'b011,32'h0,MRD,32'h0000_3014, 1,1,5'd9,32'h0000_7F01,32'h0000_3014,32'd5);
        step(0,0,0, 1,1,5'd10,2'b01,3'b000,32'h0,MRD,32'h0000_3018, 1,1,5'd10,32'h80FF_7F01,32'h0000_3018,32'd6);
        step(0,0,0, 1,1,5'd11,2'b01,3'b111,32'h2,MRD,32'h0000_301C, 1,1,5'd11,32'h80FF_7F01,32'h0000_301C,32'd7);
        step(0,0,0, 1,1,5'd12,2'b01,3'b011,32'h3,MRD,32'h0000_3020, 1,1,5'd12,32'h0000_80FF,32'h0000_3020,32'd8);
        step(0,0,0, 1,1,5'd15,2'b01,3'b010,32'h1,MRD,32'h0000_3024, 1,1,5'd15,32'h0000_007F,32'h0000_3024,32'd9);
        step(0,0,0, 1,1,5'd16,2'b01,3'b100,32'h1,MRD,32'h0000_3028, 1,1,5'd16,32'h0000_7F01,32'h0000_3028,32'd10);
        // jal link value
        step(0,0,0, 1,1,5'd31,2'b10,3'd0,32'h0,32'h0,32'h0000_3010, 1,1,5'd31,32'h0000_3014,32'h0000_3010,32'd11);
        // Source 11 drives zero
        step(0,0,0, 1,1,5'd3,2'b11,3'd0,32'hDEAD_BEEF,MRD,32'h0000_302C, 1,1,5'd3,32'h0,32'h0000_302C,32'd12);
        // Write to $0 is suppressed but retires
        step(0,0,0, 1,1,5'd0,2'b00,3'd0,32'h0000_0055,32'h0,32'h0000_3030, 1,0,5'd0,32'h0000_0055,32'h0000_3030,32'd13);
        // Instruction without a register write
        step(0,0,0, 1,0,5'd4,2'b00,3'd0,32'h0000_0077,32'h0,32'h0000_3034, 1,0,5'd4,32'h0000_0077,32'h0000_3034,32'd14);
        // Bubble carrying RegWrite=1 never writes, does not retire
        step(0,0,0, 0,1,5'd4,2'b00,3'd0,32'h0000_0088,32'h0,32'h0000_3038, 0,0,5'd4,32'h0000_0088,32'h0000_3038,32'd14);
        // Real instruction, then stall for three cycles with new inputs
        step(0,0,0, 1,1,5'd13,2'b00,3'd0,32'hCAFE_BABE,32'h0,32'h0000_303C, 1,1,5'd13,32'hCAFE_BABE,32'h0000_303C,32'd15);
        for (int i = 0; i < 3; i++)
            step(0,1,0, 1,1,5'd20,2'b00,3'd0,32'h0000_1111,32'h0,32'h0000_4000, 1,1,5'd13,32'hCAFE_BABE,32'h0000_303C,32'd15);
        // Flush with Stall high: bubble, PC4 and count hold
        step(0,1,1, 1,1,5'd20,2'b00,3'd0,32'h0000_1111,32'h0,32'h0000_4000, 0,0,5'd0,32'h0,32'h0000_303C,32'd15);
        step(0,0,0, 1,1,5'd14,2'b00,3'd0,32'h0000_0042,32'h0,32'h0000_3040, 1,1,5'd14,32'h0000_0042,32'h0000_3040,32'd16);
        // Flush alone
        step(0,0,1, 1,1,5'd21,2'b01,3'b010,32'h3,MRD,32'h0000_5000, 0,0,5'd0,32'h0,32'h0000_3040,32'd16);
        step(0,0,0, 1,1,5'd17,2'b00,3'd0,32'h0000_0099,32'h0,32'h0000_3044, 1,1,5'd17,32'h0000_0099,32'h0000_3044,32'd17);
        // Reset mid-stream with a valid instruction presented
        step(1,0,0, 1,1,5'd18,2'b00,3'd0,32'h0000_00AA,32'h0,32'h0000_3048, 0,0,5'd0,32'h0,32'h0000_3000,32'd0);
        // PC+8 wraps modulo 2^32
        step(0,0,0, 1,1,5'd31,2'b10,3'd0,32'h0,32'h0,32'hFFFF_FFFC, 1,1,5'd31,32'h0,32'hFFFF_FFFC,32'd1);
        step(0,0,0, 0,0,5'd0,2'b00,3'd0,32'h0,32'h0,32'h0000_3000, 0,0,5'd0,32'h0,32'h0000_3000,32'd1);

        // Let the monitor drain, bounded
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge Clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline register and write-back datapath of the five-stage pipelined CPU. It captures the memory-stage results each cycle and performs load-data alignment and sign/zero extension. It selects the register write value and drives the register file's write port (write enable, destination, data, PC+4). It also keeps a retired-instruction counter for debug and trace.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC+4 value loaded into W_PC4 on reset.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- Stall  in  1  hold the WB register contents.
- Flush  in  1  load a bubble into WB.
- M_Valid  in  1  memory-stage slot holds a real instruction.
- M_RegWrite  in  1  instruction writes a GPR.
- M_A3  in  5  destination register.
- M_WbSel  in  2  write source: 00 ALU, 01 memory, 10 PC+8, 11 drives zero.
- M_LoadType  in  3  000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh; other codes treated as lw.
- M_ALUOut  in  32  ALU result; bits [1:0] are the byte offset for loads.
- M_MemRD  in  32  raw word read from data memory.
- M_PC4  in  32  PC+4 of the instruction.
- W_Valid  out  1  WB slot holds a real instruction.
- W_RegWrite  out  1  register-file write enable.
- W_A3  out  5  register-file write address (also to the hazard unit).
- W_WriteData  out  32  register-file write data.
- W_PC4  out  32  PC+4 of the WB instruction, for the write trace.
- RetireCount  out  32  count of instructions that entered WB.

## Operation
- Registered fields: Valid, RegWrite, A3, WbSel, LoadType, ALUOut, MemRD, PC4.
- Edge priority: Reset > Flush > Stall > normal load.
- Reset:
  - Valid=0, RegWrite=0, A3=0, WbSel=00, LoadType=000, ALUOut=0, MemRD=0.
  - PC4=RESET_PC.
  - RetireCount=0.
- Flush: same field values as Reset, except PC4 and RetireCount hold.
- Stall (no Flush): all fields and RetireCount hold.
- Normal: all fields load from the M_* inputs.
- W_RegWrite = Valid & RegWrite & (A3 != 0), combinational from registered fields.
  - Destination $0 is never written.
  - A bubble never writes.
- Load extension (combinational; off = ALUOut[1:0]):
  - lw: MemRD.
  - lbu / lb: byte MemRD[8*off+7 : 8*off], zero-extended (lbu) or sign-extended (lb).
  - lhu / lh: halfword off[1] ? MemRD[31:16] : MemRD[15:0], zero-extended (lhu) or sign-extended (lh); off[0] is ignored.
- Write data by WbSel:
  - 00: ALUOut.
  - 01: extended load data.
  - 10: PC4 + 4, modulo 2^32.
  - 11: 32'h0.
- RetireCount increments by 1 on an edge with normal load and M_Valid=1.
  - Never increments on Reset, Flush or Stall edges.
  - Wraps from 32'hFFFF_FFFF to 0.
- W_Valid = registered Valid. W_A3 = registered A3, even when W_RegWrite=0.

## Timing
- Latency: one cycle. Values presented on M_* before edge N appear on W_* after edge N.
- W_WriteData and W_RegWrite are combinational from the WB register. They are valid for the whole cycle and are sampled by the register file at the next edge.
- Stall held for k cycles: W_* stay constant for k cycles; the register file may rewrite the same value each cycle, which is harmless.
- Stall and Flush asserted together: Flush wins and a bubble is loaded.
- Reset asserted mid-stream: the next edge clears everything; W_RegWrite=0 from that edge on.

## Test plan
- Reset, then idle: all outputs 0, W_PC4=32'h0000_3000, RetireCount=0.
- ALU write, M_A3=5, M_ALUOut=32'h1234_5678, M_WbSel=00 -> next cycle W_RegWrite=1, W_A3=5, W_WriteData=32'h1234_5678, RetireCount=1.
- Loads with M_MemRD=32'h80FF_7F01, M_WbSel=01:
  - lb, offset 3 -> W_WriteData=32'hFFFF_FF80.
  - lbu, offset 2 -> 32'h0000_00FF.
  - lh, offset 2 -> 32'hFFFF_80FF.
  - lhu, offset 0 -> 32'h0000_7F01.
- jal: M_WbSel=10, M_PC4=32'h0000_3010, M_A3=31 -> W_WriteData=32'h0000_3014.
- Write to $0 with M_RegWrite=1, M_A3=0 -> W_RegWrite=0, RetireCount still increments.
- Stall for 3 cycles, then Flush with Stall high:
  - W_* and RetireCount hold during the stall.
  - After the flush edge: W_Valid=0, W_RegWrite=0, RetireCount unchanged.
